// File: rtl/vga_pkg.sv
// Shared constants and types for the 800x480 raster timing generator.
// Timing values here are defaults only; vga_timing exposes them as parameters.
package vga_pkg;

  localparam int CNT_W = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int RGB_W = 24;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef logic [CNT_W-1:0] count_t;

  // Inclusive window test used for the sync pulses.
  function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Cleared shift register: DEPTH stages of WIDTH bits, every stage reset to RESET_VAL,
// so a fresh pipeline only ever emits the inactive value until real data arrives.
module sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Raster counters, sync/DE generation and pixel output stage aligned to the frame
// buffer read latency. Optional checkerboard source enabled by VGA_TEST_PATTERN_EN.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int PIX_LATENCY = 1,
  parameter logic [RGB_W-1:0] FG_RGB = 24'hFFFFFF,
  parameter logic [RGB_W-1:0] BG_RGB = 24'h000000
) (
  input  logic             clk,
  input  logic             reset,
  output count_t           vga_h,
  output count_t           vga_v,
  input  logic             pixel_in,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic             test_mode
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam count_t H_LAST   = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST   = count_t'(V_TOTAL - 1);
  localparam count_t H_ACT    = count_t'(H_ACTIVE);
  localparam count_t V_ACT    = count_t'(V_ACTIVE);
  localparam count_t HS_FIRST = count_t'(H_ACTIVE + H_FP);
  localparam count_t HS_LAST  = count_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam count_t VS_FIRST = count_t'(V_ACTIVE + V_FP);
  localparam count_t VS_LAST  = count_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
    $error("vga_timing: H_TOTAL/V_TOTAL exceed the 11-bit count range");
  end
  if (PIX_LATENCY < 1 || PIX_LATENCY > 4) begin : g_bad_latency
    $error("vga_timing: PIX_LATENCY must be in 1..4");
  end

  count_t h_cnt;
  count_t v_cnt;

  // v advances on the same edge h wraps; both roll over together at end of frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? count_t'(0) : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign vga_h = h_cnt;
  assign vga_v = v_cnt;

  // Gated by reset so the pulse only marks a live frame origin, not the held reset state.
  assign frame_start = ~reset & (h_cnt == '0) & (v_cnt == '0);

  logic de_raw;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    de_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_raw = in_window(h_cnt, HS_FIRST, HS_LAST);
    vs_raw = in_window(v_cnt, VS_FIRST, VS_LAST);
  end

  // Pipeline carries active-high flags; polarity is applied at the pins.
  logic [2:0] timing_d;
  logic       de_d;
  logic       hs_d;
  logic       vs_d;

  sync_delay #(
    .WIDTH     (3),
    .DEPTH     (PIX_LATENCY),
    .RESET_VAL (3'b000)
  ) u_timing_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({de_raw, hs_raw, vs_raw}),
    .q     (timing_d)
  );

  assign {de_d, hs_d, vs_d} = timing_d;

  assign de    = de_d;
  assign hsync = hs_d ? HS_POL : ~HS_POL;
  assign vsync = vs_d ? VS_POL : ~VS_POL;

  logic pix_src;

`ifdef VGA_TEST_PATTERN_EN
  // The checkerboard only needs bit 4 of each coordinate, so only those bits are delayed.
  logic [1:0] hv4_d;

  sync_delay #(
    .WIDTH     (2),
    .DEPTH     (PIX_LATENCY),
    .RESET_VAL (2'b00)
  ) u_hv_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({h_cnt[4], v_cnt[4]}),
    .q     (hv4_d)
  );

  always_comb begin
    pix_src = pixel_in;
    if (test_mode) begin
      pix_src = hv4_d[1] ^ hv4_d[0];
    end
  end
`else
  always_comb begin
    pix_src = pixel_in;
  end
`endif

  always_comb begin
    rgb = '0;
    if (de_d) begin
      rgb = pix_src ? FG_RGB : BG_RGB;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing on a reduced raster so several frames fit in a short run;
// expectations come from arithmetic on the elapsed cycle count since reset release.
module tb_vga_timing;

  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 6;
  localparam int VA  = 20;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int L   = 2;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] vga_h;
  logic [10:0] vga_v;
  logic        pixel_in;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb;
  logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode;
`endif

  int t;
  bit pix_bit;
  bit tm_bit;
  int errors;
  int n_checks;
  int fs_seen;
  int hs_low_seen;

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE    (HA),
    .H_FP        (HFP),
    .H_SYNC      (HS),
    .H_BP        (HBP),
    .V_ACTIVE    (VA),
    .V_FP        (VFP),
    .V_SYNC      (VS),
    .V_BP        (VBP),
    .HS_POL      (1'b0),
    .VS_POL      (1'b0),
    .PIX_LATENCY (L),
    .FG_RGB      (FG),
    .BG_RGB      (BG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vga_h       (vga_h),
    .vga_v       (vga_v),
    .pixel_in    (pixel_in),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .test_mode   (test_mode)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_h", 32'(vga_h), 32'd0);
    chk("rst_v", 32'(vga_v), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
  endtask

  // Reference: counts are (t mod line, line mod frame); delayed outputs use t-L.
  task automatic check_all();
    int h, v, hd, vd;
    bit act, de_e, hs_a, vs_a, src;
    logic [23:0] rgb_e;
    h = t % HT;
    v = (t / HT) % VT;
    act = (t >= L);
    hd = act ? (t - L) % HT : 0;
    vd = act ? ((t - L) / HT) % VT : 0;
    de_e = act && (hd < HA) && (vd < VA);
    hs_a = act && (hd >= HA + HFP) && (hd <= HA + HFP + HS - 1);
    vs_a = act && (vd >= VA + VFP) && (vd <= VA + VFP + VS - 1);
    src = pix_bit;
    if (tm_bit) src = hd[4] ^ vd[4];
    rgb_e = de_e ? (src ? FG : BG) : 24'h0;
    chk("vga_h", 32'(vga_h), 32'(h));
    chk("vga_v", 32'(vga_v), 32'(v));
    chk("frame_start", 32'(frame_start), 32'((h == 0) && (v == 0)));
    chk("de", 32'(de), 32'(de_e));
    chk("hsync", 32'(hsync), 32'(!hs_a));
    chk("vsync", 32'(vsync), 32'(!vs_a));
    chk("rgb", 32'(rgb), 32'(rgb_e));
    if (frame_start === 1'b1) fs_seen++;
  endtask

  // mode 0: random pixel bits; mode 1: pixel = column parity of the count L cycles ago.
  task automatic step(input int mode);
    @(posedge clk);
    t++;
    #1;
    if (mode == 0) pix_bit = bit'($urandom_range(0, 1));
    else pix_bit = (t >= L) ? bit'(((t - L) % HT) & 1) : 1'b0;
    pixel_in = pix_bit;
    #1;
    check_all();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    t = 0;
    #1;
    check_all();
  endtask

  initial begin
    errors = 0;
    n_checks = 0;
    fs_seen = 0;
    hs_low_seen = 0;
    t = 0;
    tm_bit = 1'b0;
    pix_bit = 1'b1;
    pixel_in = 1'b1;
    reset = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif

    // Reset held for 5 clocks with pixel_in high: outputs must stay inactive.
    repeat (5) begin
      @(posedge clk);
      #1;
      chk_reset_vals();
    end
    release_reset();

    // Random pixels across two full frames; count hsync-low cycles in the first full delayed line.
    for (int i = 0; i < 2 * FRAME + 100; i++) begin
      step(0);
      if (t >= L && t < L + HT && hsync === 1'b0) hs_low_seen++;
    end
    chk("hs_low_per_line", 32'(hs_low_seen), 32'(HS));
    chk("frame_start_count", 32'(fs_seen), 32'd3);

    // Alignment: pixel_in echoes the delayed column parity, rgb must alternate on active columns.
    for (int i = 0; i < 3 * HT; i++) begin
      step(1);
      if (de === 1'b1) chk("align_rgb", 32'(rgb), 32'(((t - L) % HT) % 2 ? FG : BG));
    end

    // Run to h=30, v=10 of the next frame, then reset asynchronously mid-cycle.
    while (!((t % FRAME) == 10 * HT + 30)) step(0);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_reset_vals();
    end
    release_reset();
    for (int i = 0; i < 2 * HT; i++) step(0);

`ifdef VGA_TEST_PATTERN_EN
    // Checkerboard source, flipped on and off at random points including mid-line.
    while ((t % FRAME) != FRAME - 1) step(0);
    tm_bit = 1'b1;
    test_mode = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > HT * (VA - 2) && i % 37 == 0) begin
        tm_bit = bit'($urandom_range(0, 1));
        test_mode = tm_bit;
      end
      step(0);
    end
    tm_bit = 1'b0;
    test_mode = 1'b0;
    for (int i = 0; i < HT; i++) step(0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
